// File: rtl/output_buffer_sequencer_if.sv
// Stream-side bundle of the output buffer sequencer: buffer descriptors, data beats,
// the flush pulse and the outgoing write-request descriptors.
interface output_buffer_sequencer_if #(
    parameter int VADDR_BITS = 48,
    parameter int SIZE_BITS  = 28
);
    // Every channel transfers on a cycle where valid and ready are both high; a source
    // holds valid and its payload steady until that cycle, and ready may depend on state only.
    logic                  buf_valid;
    logic                  buf_ready;
    logic [VADDR_BITS-1:0] buf_vaddr;
    logic [SIZE_BITS-1:0]  buf_size;
    logic                  flush_buffers;
    logic                  beat_valid;
    logic                  beat_ready;
    logic                  beat_last;
    logic                  req_valid;
    logic                  req_ready;
    logic [VADDR_BITS-1:0] req_vaddr;
    logic [SIZE_BITS-1:0]  req_len;
    logic                  req_last;
    logic                  req_buf_end;

    modport master (
        output buf_valid, buf_vaddr, buf_size, flush_buffers, beat_valid, beat_last, req_ready,
        input  buf_ready, beat_ready, req_valid, req_vaddr, req_len, req_last, req_buf_end
    );

    modport slave (
        input  buf_valid, buf_vaddr, buf_size, flush_buffers, beat_valid, beat_last, req_ready,
        output buf_ready, beat_ready, req_valid, req_vaddr, req_len, req_last, req_buf_end
    );
endinterface

// File: rtl/output_buffer_sequencer.sv
// Packs the data beats of one output stream into host buffers and issues one
// write-request descriptor per closed chunk (max-size, buffer-full, stream-last or flush).
module output_buffer_sequencer #(
    parameter int VADDR_BITS     = 48,
    parameter int SIZE_BITS      = 28,
    parameter int BEAT_BYTES     = 64,
    parameter int MAX_XFER_BYTES = 4096
) (
    input  logic                         clk,
    input  logic                         rst_n,
    output_buffer_sequencer_if.slave     bus,
    output logic [63:0]                  total_bytes,
    output logic [1:0]                   dbg_state
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FILL = 2'd1;
    localparam logic [1:0] EMIT = 2'd2;

    localparam logic [SIZE_BITS-1:0] BEAT      = SIZE_BITS'(BEAT_BYTES);
    localparam logic [SIZE_BITS-1:0] MAX_XFER  = SIZE_BITS'(MAX_XFER_BYTES);
    localparam logic [SIZE_BITS-1:0] BEAT_MASK = ~(BEAT - SIZE_BITS'(1));

    logic [1:0]            state;
    logic [VADDR_BITS-1:0] base;
    logic [SIZE_BITS-1:0]  cap;
    logic [SIZE_BITS-1:0]  buf_off;
    logic [SIZE_BITS-1:0]  chunk_start;
    logic [SIZE_BITS-1:0]  chunk_bytes;
    logic                  flush_pending;
    logic [VADDR_BITS-1:0] req_vaddr_q;
    logic [SIZE_BITS-1:0]  req_len_q;
    logic                  req_last_q;
    logic                  req_buf_end_q;

    logic [SIZE_BITS-1:0]  eff_size;
    logic [SIZE_BITS-1:0]  step;
    logic [SIZE_BITS-1:0]  new_chunk;
    logic [SIZE_BITS-1:0]  new_off;
    logic                  buf_hs;
    logic                  beat_hs;
    logic                  req_hs;
    logic                  is_full;
    logic                  is_last;
    logic                  close;

    // Ready/valid are gated by rst_n so nothing handshakes while reset is held.
    assign bus.buf_ready   = rst_n && (state == IDLE);
    assign bus.beat_ready  = rst_n && (state == FILL);
    assign bus.req_valid   = rst_n && (state == EMIT);
    assign bus.req_vaddr   = req_vaddr_q;
    assign bus.req_len     = req_len_q;
    assign bus.req_last    = req_last_q;
    assign bus.req_buf_end = req_buf_end_q;
    assign dbg_state       = state;

    assign eff_size  = bus.buf_size & BEAT_MASK;
    assign buf_hs    = bus.buf_valid && bus.buf_ready;
    assign beat_hs   = bus.beat_valid && bus.beat_ready;
    assign req_hs    = bus.req_valid && bus.req_ready;
    assign step      = beat_hs ? BEAT : '0;
    assign new_chunk = chunk_bytes + step;
    assign new_off   = buf_off + step;
    assign is_full   = beat_hs && (new_off == cap);
    assign is_last   = beat_hs && bus.beat_last;
    assign close     = beat_hs && ((new_chunk == MAX_XFER) || is_full || is_last);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            base          <= '0;
            cap           <= '0;
            buf_off       <= '0;
            chunk_start   <= '0;
            chunk_bytes   <= '0;
            flush_pending <= 1'b0;
            req_vaddr_q   <= '0;
            req_len_q     <= '0;
            req_last_q    <= 1'b0;
            req_buf_end_q <= 1'b0;
            total_bytes   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    flush_pending <= 1'b0;
                    // Descriptors smaller than one beat are consumed and dropped.
                    if (buf_hs && (eff_size != '0)) begin
                        base        <= bus.buf_vaddr;
                        cap         <= eff_size;
                        buf_off     <= '0;
                        chunk_start <= '0;
                        chunk_bytes <= '0;
                        state       <= FILL;
                    end
                end
                FILL: begin
                    buf_off     <= new_off;
                    chunk_bytes <= new_chunk;
                    if (bus.flush_buffers && (new_chunk == '0)) begin
                        state <= IDLE;
                    end else if (bus.flush_buffers || close) begin
                        req_vaddr_q   <= base + VADDR_BITS'(chunk_start);
                        req_len_q     <= new_chunk;
                        req_last_q    <= is_last;
                        req_buf_end_q <= bus.flush_buffers || is_full || is_last;
                        state         <= EMIT;
                    end
                end
                EMIT: begin
                    if (bus.flush_buffers) begin
                        flush_pending <= 1'b1;
                    end
                    if (req_hs) begin
                        total_bytes <= total_bytes + 64'(req_len_q);
                        // A flush seen at any point during the stall ends the buffer here.
                        if (req_buf_end_q || flush_pending || bus.flush_buffers) begin
                            flush_pending <= 1'b0;
                            state         <= IDLE;
                        end else begin
                            chunk_start <= buf_off;
                            chunk_bytes <= '0;
                            state       <= FILL;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_output_buffer_sequencer.sv
// Self-checking bench for output_buffer_sequencer: table of single-buffer streams,
// then hand sequences for reset, small/dropped buffers, flush, back-pressure and reset-in-EMIT.
module tb_output_buffer_sequencer;
    localparam int VB = 48;
    localparam int SB = 28;
    localparam int W  = VB + SB + 2;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_EMIT = 2'd2;

    // Clock and reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    output_buffer_sequencer_if #(.VADDR_BITS(VB), .SIZE_BITS(SB)) bus ();
    logic [63:0] total_bytes;
    logic [1:0]  dbg_state;

    output_buffer_sequencer #(
        .VADDR_BITS(VB), .SIZE_BITS(SB), .BEAT_BYTES(64), .MAX_XFER_BYTES(4096)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .total_bytes(total_bytes), .dbg_state(dbg_state)
    );

    // Scoreboard
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass = 0;
    logic [63:0] exp_total = '0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [W-1:0] pack_req(input logic [VB-1:0] a, input logic [SB-1:0] len,
                                              input logic last, input logic bend);
        return {a, len, last, bend};
    endfunction

    // Reference packing of one buffer: 64-byte beats, 4096-byte request limit.
    function automatic void model_push(input logic [VB-1:0] base, input logic [SB-1:0] size,
                                       input int nbeats, input bit last);
        logic [SB-1:0] eff, off, cs, cb;
        bit full, l;
        eff = SB'((size / 64) * 64);
        off = '0; cs = '0; cb = '0;
        for (int i = 0; i < nbeats; i++) begin
            cb = cb + SB'(64);
            off = off + SB'(64);
            full = (off == eff);
            l = last && (i == nbeats - 1);
            if (cb == SB'(4096) || full || l) begin
                exp_q.push_back(pack_req(base + VB'(cs), cb, l, full || l));
                if (full || l) break;
                cs = off;
                cb = '0;
            end
        end
    endfunction

    always @(negedge clk) begin : monitor
        logic [W-1:0] e;
        if (rst_n && bus.req_valid && bus.req_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_req: got vaddr 0x%0h len %0d, expected no request",
                         bus.req_vaddr, bus.req_len);
            end else begin
                e = exp_q.pop_front();
                check("req", {bus.req_vaddr, bus.req_len, bus.req_last, bus.req_buf_end}, e);
            end
        end
    end

    // Driver tasks: all start and end at posedge + #1
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_buf(input logic [VB-1:0] a, input logic [SB-1:0] s);
        bit ok;
        ok = 1'b0;
        bus.buf_valid = 1'b1; bus.buf_vaddr = a; bus.buf_size = s;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk); ok = bus.buf_ready;
            @(posedge clk); #1;
        end
        bus.buf_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            $display("FAIL buf_timeout: got no buf_ready, expected handshake for 0x%0h", a);
        end
    endtask

    task automatic drive_beats(input int n, input bit last_at_end);
        bit ok;
        for (int i = 0; i < n; i++) begin
            bus.beat_valid = 1'b1;
            bus.beat_last = last_at_end && (i == n - 1);
            ok = 1'b0;
            for (int t = 0; t < 300 && !ok; t++) begin
                @(negedge clk); ok = bus.beat_ready;
                @(posedge clk); #1;
            end
            if (!ok) begin
                n_checks++;
                $display("FAIL beat_timeout: got no beat_ready on beat %0d, expected handshake", i);
                break;
            end
        end
        bus.beat_valid = 1'b0;
        bus.beat_last = 1'b0;
    endtask

    task automatic pulse_flush();
        bus.flush_buffers = 1'b1;
        @(posedge clk); #1;
        bus.flush_buffers = 1'b0;
    endtask

    task automatic wait_idle(input int q_left);
        bit done;
        done = 1'b0;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            done = (dbg_state == S_IDLE) && (exp_q.size() == q_left);
        end
        @(posedge clk); #1;
        if (!done) begin
            n_checks++;
            $display("FAIL idle_timeout: got state %0d queue %0d, expected IDLE queue %0d",
                     dbg_state, exp_q.size(), q_left);
        end
    endtask

    task automatic wait_req();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk); done = bus.req_valid;
        end
        @(posedge clk); #1;
        if (!done) begin
            n_checks++;
            $display("FAIL req_timeout: got req_valid 0, expected 1");
        end
    endtask

    typedef struct {
        logic [VB-1:0] vaddr;
        logic [SB-1:0] size;
        int            nbeats;
        bit            last;
        logic [63:0]   exp_bytes;
    } vec_t;
    vec_t vecs[9];

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1);
    end

    initial begin
        int capb;
        bus.buf_valid = 0; bus.buf_vaddr = '0; bus.buf_size = '0; bus.flush_buffers = 0;
        bus.beat_valid = 0; bus.beat_last = 0; bus.req_ready = 1;

        vecs[0] = '{48'h1000, 28'd8192, 128, 1'b1, 64'd8192};
        vecs[1] = '{48'h4000, 28'd256, 4, 1'b0, 64'd256};
        vecs[2] = '{48'hFFFF_FFFF_F800, 28'd8192, 70, 1'b1, 64'd4480};
        vecs[3] = '{48'h20000, 28'd4100, 64, 1'b0, 64'd4096};
        vecs[4] = '{48'h30000, 28'd130, 2, 1'b1, 64'd128};
        for (int i = 5; i < 9; i++) begin
            vecs[i].vaddr = VB'({$urandom(), $urandom()}) & ~VB'(63);
            vecs[i].size = SB'($urandom_range(64, 12000));
            capb = int'(vecs[i].size) / 64;
            vecs[i].nbeats = $urandom_range(1, capb);
            vecs[i].last = (vecs[i].nbeats < capb) ? 1'b1 : 1'($urandom_range(0, 1));
            vecs[i].exp_bytes = 64'(vecs[i].nbeats * 64);
        end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_buf_ready", bus.buf_ready, 0);
        check("rst_beat_ready", bus.beat_ready, 0);
        check("rst_req_valid", bus.req_valid, 0);
        check("rst_total", total_bytes, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_buf_ready", bus.buf_ready, 1);
        check("idle_state", dbg_state, S_IDLE);
        check("rst_req_fields", {bus.req_vaddr, bus.req_len, bus.req_last, bus.req_buf_end}, 0);
        @(posedge clk); #1;

        // Table-driven single-buffer streams
        for (int i = 0; i < 9; i++) begin
            model_push(vecs[i].vaddr, vecs[i].size, vecs[i].nbeats, vecs[i].last);
            send_buf(vecs[i].vaddr, vecs[i].size);
            drive_beats(vecs[i].nbeats, vecs[i].last);
            wait_idle(0);
            exp_total += vecs[i].exp_bytes;
            check($sformatf("vec%0d_total", i), total_bytes, exp_total);
            check($sformatf("vec%0d_beat_ready", i), bus.beat_ready, 0);
        end

        // Tiny buffer: one beat fills it, remaining beats wait for the next descriptor
        exp_q.push_back(pack_req(48'h5000, 28'd64, 1'b0, 1'b1));
        exp_q.push_back(pack_req(48'h6000, 28'd128, 1'b1, 1'b1));
        fork
            drive_beats(3, 1'b1);
            begin
                send_buf(48'h5000, 28'd100);
                wait_idle(1);
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check("idle_hold_beat_ready", bus.beat_ready, 0);
                    @(posedge clk); #1;
                end
                send_buf(48'h6000, 28'd1024);
            end
        join
        wait_idle(0);
        exp_total += 64'd192;
        check("small_buf_total", total_bytes, exp_total);

        // Sub-beat descriptor is dropped; the next one carries the beats
        send_buf(48'h7000, 28'd32);
        @(negedge clk);
        check("drop_state", dbg_state, S_IDLE);
        @(posedge clk); #1;
        model_push(48'h8000, 28'd256, 4, 1'b0);
        send_buf(48'h8000, 28'd256);
        drive_beats(4, 1'b0);
        wait_idle(0);
        exp_total += 64'd256;
        check("drop_total", total_bytes, exp_total);

        // Flush of a partial chunk in FILL
        exp_q.push_back(pack_req(48'h9000, 28'd320, 1'b0, 1'b1));
        send_buf(48'h9000, 28'd4096);
        drive_beats(5, 1'b0);
        cycles(2);
        pulse_flush();
        wait_idle(0);
        exp_total += 64'd320;
        check("flush_fill_total", total_bytes, exp_total);

        // Flush in IDLE and in FILL with an empty chunk: no request
        pulse_flush();
        cycles(3);
        send_buf(48'h9800, 28'd4096);
        cycles(1);
        pulse_flush();
        @(negedge clk);
        check("flush_empty_state", dbg_state, S_IDLE);
        check("flush_empty_req_valid", bus.req_valid, 0);
        check("flush_empty_total", total_bytes, exp_total);
        @(posedge clk); #1;

        // Back-pressure in EMIT: fields hold, beats are stalled, none lost
        bus.req_ready = 1'b0;
        model_push(48'hA000, 28'd8192, 70, 1'b1);
        fork
            drive_beats(70, 1'b1);
            begin
                send_buf(48'hA000, 28'd8192);
                wait_req();
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    check("stall_req_valid", bus.req_valid, 1);
                    check("stall_beat_ready", bus.beat_ready, 0);
                    check("stall_vaddr", bus.req_vaddr, 48'hA000);
                    check("stall_len", bus.req_len, 28'd4096);
                    @(posedge clk); #1;
                end
                bus.req_ready = 1'b1;
            end
        join
        wait_idle(0);
        exp_total += 64'd4480;
        check("stall_total", total_bytes, exp_total);

        // Flush while stalled: the mid-buffer request completes, then IDLE
        bus.req_ready = 1'b0;
        exp_q.push_back(pack_req(48'hC000, 28'd4096, 1'b0, 1'b0));
        send_buf(48'hC000, 28'd8192);
        drive_beats(64, 1'b0);
        cycles(3);
        pulse_flush();
        cycles(2);
        @(negedge clk);
        check("flush_stall_buf_end", {bus.req_valid, bus.req_buf_end}, 2'b10);
        @(posedge clk); #1;
        bus.req_ready = 1'b1;
        wait_idle(0);
        cycles(5);
        @(negedge clk);
        check("flush_stall_state", dbg_state, S_IDLE);
        check("flush_stall_beat_ready", bus.beat_ready, 0);
        exp_total += 64'd4096;
        check("flush_stall_total", total_bytes, exp_total);
        @(posedge clk); #1;

        // Reset while in EMIT drops the request
        bus.req_ready = 1'b0;
        send_buf(48'hD000, 28'd256);
        drive_beats(4, 1'b0);
        @(negedge clk);
        check("pre_rst_state", dbg_state, S_EMIT);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("emit_rst_req_valid", bus.req_valid, 0);
        check("emit_rst_total", total_bytes, 0);
        check("emit_rst_state", dbg_state, S_IDLE);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.req_ready = 1'b1;
        exp_total = '0;
        model_push(48'hE000, 28'd128, 2, 1'b0);
        send_buf(48'hE000, 28'd128);
        drive_beats(2, 1'b0);
        wait_idle(0);
        exp_total += 64'd128;
        check("post_rst_total", total_bytes, exp_total);
        check("final_queue_empty", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
